pixel_splitter: RTL

Unpacks DATA_WIDTH-bit words into a serial stream of PIXEL_WIDTH-bit pixels, one pixel per transfer. It is the inverse of the word-packing stage on the filter output path, and sits between the word-wide memory/bus read side and the per-pixel filter pipeline. Pixel order within a word is least-significant first: bits [PIXEL_WIDTH-1:0] are emitted first. A one-word pending buffer lets the block sustain one pixel per cycle across word boundaries.

---
 rtl/pixel_splitter_pkg.sv | 12 +
 rtl/pixel_splitter.sv | 101 ++++++++++
 2 files changed

// File: rtl/pixel_splitter_pkg.sv
// Shared pixel/word geometry for the packing and unpacking stages.
package pixel_splitter_pkg;

    localparam int PIXEL_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF  = 32;

    // Pixels carried by one bus word.
    function automatic int pixel_number(input int data_width, input int pixel_width);
        return data_width / pixel_width;
    endfunction

endpackage

// File: rtl/pixel_splitter.sv
// Word-to-pixel unpacker: LSB pixel first, one active word being shifted out
// plus a one-word pending buffer so word boundaries cost no bubble.
module pixel_splitter
    import pixel_splitter_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic                   is_data_valid,
    output logic                   data_ready,
    output logic [PIXEL_WIDTH-1:0] pixel,
    output logic                   is_pixel_valid,
    input  logic                   pixel_ready,
    output logic                   is_last
);

    localparam int PIXEL_NUMBER  = pixel_number(DATA_WIDTH, PIXEL_WIDTH);
    localparam int COUNTER_WIDTH = (PIXEL_NUMBER > 1) ? $clog2(PIXEL_NUMBER) : 1;
    localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(PIXEL_NUMBER - 1);

    logic [DATA_WIDTH-1:0]    active_q, active_d;
    logic                     active_valid_q, active_valid_d;
    logic [DATA_WIDTH-1:0]    pending_q, pending_d;
    logic                     pending_valid_q, pending_valid_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;

    logic accept, pop, last_pop, at_last;

    assign at_last        = (count_q == LAST_IDX);
    assign data_ready     = reset && !pending_valid_q;
    assign accept         = is_data_valid && data_ready;
    assign pop            = active_valid_q && pixel_ready;
    assign last_pop       = pop && at_last;

    assign pixel          = active_q[PIXEL_WIDTH-1:0];
    assign is_pixel_valid = active_valid_q;
    assign is_last        = active_valid_q && at_last;

    // Next state: load empty active, hand over at word end, otherwise shift/park.
    always_comb begin
        active_d        = active_q;
        active_valid_d  = active_valid_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        count_d         = count_q;

        if (!active_valid_q) begin
            // pending is never valid here, so only the direct load applies
            if (accept) begin
                active_d       = data;
                active_valid_d = 1'b1;
                count_d        = '0;
            end
        end else if (last_pop) begin
            count_d = '0;
            if (pending_valid_q) begin
                active_d = pending_q;
                if (accept) begin
                    pending_d = data;
                end else begin
                    pending_valid_d = 1'b0;
                end
            end else if (accept) begin
                active_d = data;
            end else begin
                active_d       = '0;
                active_valid_d = 1'b0;
            end
        end else begin
            if (pop) begin
                active_d = active_q >> PIXEL_WIDTH;
                count_d  = count_q + 1'b1;
            end
            if (accept) begin
                pending_d       = data;
                pending_valid_d = 1'b1;
            end
        end
    end

    // State registers; reset drops both active and pending words.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_q        <= '0;
            active_valid_q  <= 1'b0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            count_q         <= '0;
        end else begin
            active_q        <= active_d;
            active_valid_q  <= active_valid_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            count_q         <= count_d;
        end
    end

endmodule
